// File: rtl/blinds_pkg.sv
// Purpose: shared types and light thresholds for the blind motor sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package blinds_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        SETTLE    = 2'd3
    } state_t;

    // Openness level: 0 = closed, 3 = fully open.
    typedef logic [1:0] level_t;

    localparam level_t LEVEL_MIN = 2'd0;
    localparam level_t LEVEL_MAX = 2'd3;

    // Lower bounds of the intensity bands; brighter light closes the blinds.
    localparam logic [3:0] THR_CLOSED = 4'd7;
    localparam logic [3:0] THR_LOW    = 4'd5;
    localparam logic [3:0] THR_MID    = 4'd3;

endpackage

// File: rtl/blinds_classifier.sv
// Purpose: maps a 4-bit light reading onto a target openness level.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the input continuously.
//
// Ports:
//   intensity  in   4  unsigned light reading
//   level      out  2  openness level (>=7:0, 5..6:1, 3..4:2, <=2:3)
module blinds_classifier
    import blinds_pkg::*;
(
    input  logic [3:0] intensity,
    output level_t     level
);

    always_comb begin
        level = 2'd3;
        if (intensity >= THR_CLOSED) begin
            level = 2'd0;
        end else if (intensity >= THR_LOW) begin
            level = 2'd1;
        end else if (intensity >= THR_MID) begin
            level = 2'd2;
        end
    end

endmodule

// File: rtl/blinds_motor_ctrl.sv
// Purpose: filters light samples into a committed blind level and steps the motor toward it.
// Latency: target commits 1 cycle after the qualifying sample; motor starts 1 cycle after that.
// Backpressure: none; samples arriving during a move only update the target, which is acted on at step boundaries.
//
// Ports:
//   clk           in   1  system clock, rising edge
//   rst           in   1  asynchronous active-high reset
//   intensity     in   4  light reading, qualified by sample_valid
//   sample_valid  in   1  single-cycle sample strobe
//   manual_en     in   1  override enable (level sensitive, wins over samples)
//   manual_level  in   2  override target level
//   motor_up      out  1  drive toward more open
//   motor_down    out  1  drive toward more closed
//   position      out  2  believed blind level
//   target        out  2  committed target level
//   busy          out  1  FSM not in IDLE
module blinds_motor_ctrl
    import blinds_pkg::*;
#(
    parameter int STEP_CYCLES    = 1000,
    parameter int STABLE_SAMPLES = 4,
    parameter int DEAD_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] intensity,
    input  logic       sample_valid,
    input  logic       manual_en,
    input  logic [1:0] manual_level,
    output logic       motor_up,
    output logic       motor_down,
    output logic [1:0] position,
    output logic [1:0] target,
    output logic       busy
);

    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int CW = $clog2(STABLE_SAMPLES + 1);

    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_SAMPLES);

    // ------------------------------------------------------------------
    // Sample stability filter
    // ------------------------------------------------------------------
    level_t          sample_level;
    level_t          last_level;
    logic [CW-1:0]   stable_cnt;
    logic [CW-1:0]   cnt_inc;
    logic            commit;

    blinds_classifier u_classifier (
        .intensity (intensity),
        .level     (sample_level)
    );

    // Run length the filter would hold if the current sample were accepted.
    always_comb begin
        cnt_inc = CW'(1);
        if (sample_level == last_level) begin
            cnt_inc = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + CW'(1);
        end
        commit = (cnt_inc == STABLE_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_level <= LEVEL_MIN;
            stable_cnt <= '0;
            target     <= LEVEL_MIN;
        end else if (manual_en) begin
            // Override wins over a coincident sample, which is simply dropped.
            target     <= manual_level;
            stable_cnt <= '0;
        end else if (sample_valid) begin
            last_level <= sample_level;
            stable_cnt <= cnt_inc;
            if (commit) begin
                target <= sample_level;
            end
        end
    end

    // ------------------------------------------------------------------
    // Motion FSM
    // ------------------------------------------------------------------
    state_t          state;
    state_t          state_nxt;
    level_t          pos_nxt;
    logic [SW-1:0]   step_cnt;
    logic [SW-1:0]   step_nxt;
    logic [DW-1:0]   dead_cnt;
    logic [DW-1:0]   dead_nxt;

    always_comb begin
        state_nxt = state;
        pos_nxt   = position;
        step_nxt  = step_cnt;
        dead_nxt  = dead_cnt;

        case (state)
            IDLE: begin
                step_nxt = '0;
                dead_nxt = '0;
                if (target > position) begin
                    state_nxt = MOVE_UP;
                end else if (target < position) begin
                    state_nxt = MOVE_DOWN;
                end
            end

            MOVE_UP: begin
                if (step_cnt == STEP_LAST) begin
                    step_nxt = '0;
                    pos_nxt  = (position == LEVEL_MAX) ? position : position + 2'd1;
                    // Decide against the freshly stepped position; any stop
                    // or reversal goes through the dead time first.
                    if (target <= pos_nxt) begin
                        state_nxt = SETTLE;
                        dead_nxt  = '0;
                    end
                end else begin
                    step_nxt = step_cnt + SW'(1);
                end
            end

            MOVE_DOWN: begin
                if (step_cnt == STEP_LAST) begin
                    step_nxt = '0;
                    pos_nxt  = (position == LEVEL_MIN) ? position : position - 2'd1;
                    if (target >= pos_nxt) begin
                        state_nxt = SETTLE;
                        dead_nxt  = '0;
                    end
                end else begin
                    step_nxt = step_cnt + SW'(1);
                end
            end

            SETTLE: begin
                if (dead_cnt == DEAD_LAST) begin
                    dead_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    dead_nxt = dead_cnt + DW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                step_nxt  = '0;
                dead_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            position <= LEVEL_MIN;
            step_cnt <= '0;
            dead_cnt <= '0;
        end else begin
            state    <= state_nxt;
            position <= pos_nxt;
            step_cnt <= step_nxt;
            dead_cnt <= dead_nxt;
        end
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state itself; the two drives are mutually exclusive
    // because they decode distinct enum values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            busy       <= 1'b0;
        end else begin
            motor_up   <= (state_nxt == MOVE_UP);
            motor_down <= (state_nxt == MOVE_DOWN);
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: doc/blinds_motor_ctrl.md
# blinds_motor_ctrl

Sequences the window-blind motor from ambient light readings. Each 4-bit intensity sample is classified into a target openness level (0..3). The level must be confirmed by consecutive identical samples before it is committed. The block then drives the motor up or down one level per fixed travel time, and enforces a motor dead time after every stop. It sits between the light-sensor sampler and the motor driver pins, and provides a manual override path.

## Interface
Parameters:
- STEP_CYCLES, 1000 — clock cycles of motor drive per one-level step (≥2)
- STABLE_SAMPLES, 4 — consecutive identical classified samples required to commit a new target (≥1)
- DEAD_CYCLES, 16 — motor-off cycles after any stop before the next move (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset; one clock, asynchronous active-high reset as decided
- intensity  in  4  light reading, unsigned, valid only with sample_valid
- sample_valid  in  1  single-cycle strobe qualifying intensity
- manual_en  in  1  level-sensitive override enable
- manual_level  in  2  override target level
- motor_up  out  1  drive blinds toward more open
- motor_down  out  1  drive blinds toward more closed
- position  out  2  current believed level, 0 = closed, 3 = fully open
- target  out  2  committed target level
- busy  out  1  high in any state other than IDLE

## Operation
- Classification: intensity ≥7 gives 0; 5..6 gives 1; 3..4 gives 2; ≤2 gives 3. Bright light closes the blinds.
- Stability filter:
  - On each sample_valid, a classified level equal to the previous classified sample increments stable_cnt, saturating at STABLE_SAMPLES.
  - A different level sets stable_cnt to 1.
  - When stable_cnt reaches STABLE_SAMPLES, target is loaded with that level.
- Manual: while manual_en=1, target = manual_level every cycle, sample_valid is ignored, and stable_cnt is held at 0. Releasing manual_en keeps the last target until the filter commits again.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, SETTLE.
  - IDLE: if target>position, go to MOVE_UP; if target<position, go to MOVE_DOWN; otherwise stay.
  - MOVE_UP/MOVE_DOWN: step_cnt counts 0..STEP_CYCLES-1. At the terminal count, position is updated by ±1 and step_cnt returns to 0. The FSM then re-evaluates target against the new position:
    - same direction still needed: stay in the move state;
    - equal or opposite direction: go to SETTLE.
  - SETTLE: dead_cnt counts 0..DEAD_CYCLES-1, then the FSM goes to IDLE.
- A target change during a move takes effect only at a step boundary; a partial step is never abandoned.
- A direction reversal always passes through SETTLE.
- Outputs are registered:
  - motor_up=1 only in MOVE_UP, motor_down=1 only in MOVE_DOWN; the two are never both high.
  - position saturates within 0..3; no wrap-around.

## Timing
- Reset values: motor_up=0, motor_down=0, position=0, target=0, busy=0, FSM=IDLE, all counters 0.
- A reset asserted mid-move stops the motor immediately (asynchronous), and position returns to 0.
- Commit latency: target updates on the clock edge after the qualifying sample_valid cycle (1 cycle).
- Move start: the FSM leaves IDLE on the edge after target differs from position, so motor output rises 2 cycles after the qualifying sample.
- Each step holds the motor for exactly STEP_CYCLES cycles. position updates on the same edge as the last motor cycle ends.
- Motor outputs drop on the edge entering SETTLE. busy stays high for DEAD_CYCLES more cycles.
- Simultaneous sample_valid and manual_en: manual wins and the sample is discarded.

## Structure
- Package blinds_pkg:
  - state enum (IDLE, MOVE_UP, MOVE_DOWN, SETTLE);
  - typedef level_t (2 bits);
  - threshold constants THR_CLOSED=7, THR_LOW=5, THR_MID=3.
- Sub-module blinds_classifier: combinational intensity → level_t using the package thresholds, shared with other light-driven blocks.
- Top: filter, FSM, step/dead counters, output registers.

## Test plan
Bench parameters: STEP_CYCLES=4, STABLE_SAMPLES=2, DEAD_CYCLES=3.
- Reset then idle → all outputs 0, busy=0 for 20 cycles with no samples.
- Two samples of intensity=1 from position 0 → target=3 one cycle after the 2nd sample, then motor_up high for 12 consecutive cycles. position steps 1, 2, 3 at 4-cycle intervals, then busy falls after 3 settle cycles.
- Samples 1, 8, 1, 8 alternating → no commit, target stays 0, motor never driven.
- Moving up toward 3 with target changed to 0 (two samples of 9) mid-step → current step completes (position=1), then SETTLE for 3 cycles with motors off, then motor_down for 4 cycles, and position reaches 0.
- manual_en=1, manual_level=2 with sample_valid and intensity=15 in the same cycle → target=2, motor_up for 8 cycles. After release, a single sample does not change target.
- rst pulsed while motor_down=1 → motor_down=0 asynchronously, position=0, FSM=IDLE, busy=0.
